// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: control-bundle bit positions and the
// default EX/MEM payload layout used by the stage registers.
package pipe_pkg;

  localparam int CTRL_W        = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 5;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [PKG_DATA_W-1:0] alu_result;
    logic [PKG_DATA_W-1:0] rs2_data;
    logic [PKG_ADDR_W-1:0] rd_addr;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: upstream valid/ready + payload, downstream valid/ready
// + registered payload, and the flush strobe.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] alu_result_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [ADDR_W-1:0] rd_addr_o;

  modport slave (
    input  valid_i, ctrl_i, alu_result_i, rs2_data_i, rd_addr_i, flush_i, ready_i,
    output ready_o, valid_o, ctrl_o, alu_result_o, rs2_data_o, rd_addr_o
  );

  modport master (
    output valid_i, ctrl_i, alu_result_i, rs2_data_i, rd_addr_i, flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o, alu_result_o, rs2_data_o, rd_addr_o
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// Generic two-slot skid register: main slot M drives the output, skid slot S
// absorbs one overflow entry so ready_o never depends combinationally on ready_i.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         flush_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         r_m_vld;
  logic         r_s_vld;
  logic [W-1:0] r_m_dat;
  logic [W-1:0] r_s_dat;
  logic         w_acc;
  logic         w_take;

  assign ready_o = !r_s_vld;
  assign valid_o = r_m_vld;
  assign data_o  = r_m_dat;
  assign w_acc   = valid_i && !r_s_vld;
  assign w_take  = r_m_vld && ready_i;

  // Flush only clears valid bits; data registers keep their last contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_m_dat <= '0;
      r_s_dat <= '0;
    end else if (flush_i) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (!r_m_vld || w_take) begin
      if (r_s_vld) begin
        r_m_vld <= 1'b1;
        r_m_dat <= r_s_dat;
        if (w_acc) begin
          r_s_dat <= data_i;
        end else begin
          r_s_vld <= 1'b0;
        end
      end else if (w_acc) begin
        r_m_vld <= 1'b1;
        r_m_dat <= data_i;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_s_vld <= 1'b1;
      r_s_dat <= data_i;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage register with skid buffering, flush, bubble gating and x0
// RegWrite squash. Optional counters enabled by EX_MEM_STAGE_PERF_EN.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef EX_MEM_STAGE_PERF_EN
  output logic [31:0]  stall_cnt_o,
  output logic [31:0]  flush_cnt_o,
`endif
  ex_mem_stage_if.slave bus
);

  localparam int PAY_W = CTRL_W + 2*DATA_W + ADDR_W;

  logic [PAY_W-1:0]  w_pay_in;
  logic [PAY_W-1:0]  w_pay_out;
  logic              w_vld;
  logic [CTRL_W-1:0] w_ctrl_m;
  logic [DATA_W-1:0] w_alu_m;
  logic [DATA_W-1:0] w_rs2_m;
  logic [ADDR_W-1:0] w_rd_m;
  logic [CTRL_W-1:0] w_ctrl_gated;

  assign w_pay_in = {bus.ctrl_i, bus.alu_result_i, bus.rs2_data_i, bus.rd_addr_i};

  pipe_skid_slot #(.W(PAY_W)) u_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (bus.valid_i),
    .ready_o (bus.ready_o),
    .data_i  (w_pay_in),
    .flush_i (bus.flush_i),
    .valid_o (w_vld),
    .ready_i (bus.ready_i),
    .data_o  (w_pay_out)
  );

  assign {w_ctrl_m, w_alu_m, w_rs2_m, w_rd_m} = w_pay_out;

  // Bubbles carry no control; a write to x0 must never reach the register file.
  always_comb begin
    w_ctrl_gated = '0;
    if (w_vld) begin
      w_ctrl_gated = w_ctrl_m;
      if (w_rd_m == '0) w_ctrl_gated[CTRL_REGWRITE] = 1'b0;
    end
  end

  assign bus.valid_o      = w_vld;
  assign bus.ctrl_o       = w_ctrl_gated;
  assign bus.alu_result_o = w_alu_m;
  assign bus.rs2_data_o   = w_rs2_m;
  assign bus.rd_addr_o    = w_rd_m;

`ifdef EX_MEM_STAGE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_vld && !bus.ready_i) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (bus.flush_i)           r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
